// File: rtl/arvi_dmem_pkg.sv
// Shared definitions for the data-memory bridge and its lane aligner.
//   state_t  : bridge FSM states (IDLE -> BUS -> DONE -> IDLE)
//   F3_*     : RISC-V load/store funct3 encodings for size and signedness
//   BE_W     : number of byte enables on the word-wide memory port
package arvi_dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane logic for a 32-bit data memory port.
// Store side: replicates store data onto every lane and builds byte enables.
// Load side: picks the addressed byte/half out of a bus word and extends it.
// Misaligned half/word offsets ignore the low address bits; undefined funct3
// values behave as a full word with no extension.
// Ports:
//   st_wdata/st_f3/st_off : right-aligned store data, funct3, addr[1:0]
//   st_data/st_be         : lane-steered store word and byte enables
//   ld_word/ld_f3/ld_off  : raw bus read word, funct3, addr[1:0]
//   ld_data               : extended load result
module dmem_lane_align
  import arvi_dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      st_f3,
  input  logic [1:0]      st_off,
  output logic [XLEN-1:0] st_data,
  output logic [BE_W-1:0] st_be,
  input  logic [XLEN-1:0] ld_word,
  input  logic [2:0]      ld_f3,
  input  logic [1:0]      ld_off,
  output logic [XLEN-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store steering: sub-word data is duplicated across lanes so the memory
  // only has to honour the byte enables.
  always_comb begin
    st_data = st_wdata;
    st_be   = '1;
    case (st_f3)
      F3_B: begin
        st_data = {(XLEN/8){st_wdata[7:0]}};
        st_be   = {{(BE_W-1){1'b0}}, 1'b1} << st_off;
      end
      F3_H: begin
        st_data = {(XLEN/16){st_wdata[15:0]}};
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load select/extend: the half select uses only addr[1].
  always_comb begin
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
    case (ld_f3)
      F3_B:    ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_H:    ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge between the core's memory stage and a word-wide bus
// with a req/ack handshake. One access per request; the core is stalled
// until the access reaches DONE. A bus that never acks is abandoned after
// TIMEOUT_CYCLES bus cycles, and the access completes with o_err=1.
// Optional build macro ARVI_DMEM_RESERVATION_EN adds LR/SC support
// (ports i_lr, i_sc) with a single-word reservation.
// Ports:
//   i_clk, i_rst                : clock, synchronous active-high reset
//   i_req_rd/i_req_wr           : load/store request (write wins if both)
//   i_addr/i_wdata/i_f3         : byte address, store data, funct3
//   o_rdata/o_err/o_stall       : load result, timeout flag, core stall
//   o_mem_req/we/addr/wdata/be  : bus request fields, held for the access
//   i_mem_rdata/i_mem_ack       : bus read word and one-cycle completion
module dmem_bridge
  import arvi_dmem_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req_rd,
  input  logic            i_req_wr,
`ifdef ARVI_DMEM_RESERVATION_EN
  input  logic            i_lr,
  input  logic            i_sc,
`endif
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_stall,
  output logic            o_err,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [BE_W-1:0] o_mem_be,
  input  logic [XLEN-1:0] i_mem_rdata,
  input  logic            i_mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, next_state;
  logic [XLEN-1:0]   word_addr;
  logic [XLEN-1:0]   st_data, ld_data;
  logic [BE_W-1:0]   st_be;
  logic [XLEN-1:0]   addr_q, wdata_q, rdata_q;
  logic [BE_W-1:0]   be_q;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              start, ack_hit, abort, sc_fail, sc_reject;

  assign word_addr = {i_addr[XLEN-1:2], 2'b00};

  dmem_lane_align #(.XLEN(XLEN)) u_align (
    .st_wdata (i_wdata),
    .st_f3    (i_f3),
    .st_off   (i_addr[1:0]),
    .st_data  (st_data),
    .st_be    (st_be),
    .ld_word  (i_mem_rdata),
    .ld_f3    (f3_q),
    .ld_off   (off_q),
    .ld_data  (ld_data)
  );

`ifdef ARVI_DMEM_RESERVATION_EN
  logic            resv_valid, lr_q, resv_match;
  logic [XLEN-1:0] resv_addr;

  assign resv_match = resv_valid && (resv_addr == word_addr);
  // A failing SC never reaches the bus.
  assign sc_reject  = i_req_wr && i_sc && !resv_match;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
      lr_q       <= 1'b0;
    end else begin
      if (start) begin
        lr_q <= i_lr && i_req_rd && !i_req_wr;
        // Every SC, and any store to the reserved word, drops the reservation.
        if (i_req_wr && (i_sc || resv_match)) resv_valid <= 1'b0;
      end
      if (sc_fail) resv_valid <= 1'b0;
      if (ack_hit && !we_q && lr_q) begin
        resv_valid <= 1'b1;
        resv_addr  <= addr_q;
      end
    end
  end
`else
  assign sc_reject = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    o_stall    = 1'b0;
    o_mem_req  = 1'b0;
    start      = 1'b0;
    ack_hit    = 1'b0;
    abort      = 1'b0;
    sc_fail    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req_rd || i_req_wr) begin
          o_stall = 1'b1;
          if (sc_reject) begin
            sc_fail    = 1'b1;
            next_state = ST_DONE;
          end else begin
            start      = 1'b1;
            next_state = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        o_stall   = 1'b1;
        o_mem_req = 1'b1;
        // An ack on the final allowed cycle still completes normally.
        if (i_mem_ack) begin
          ack_hit    = 1'b1;
          next_state = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          abort      = 1'b1;
          next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (start) begin
        addr_q  <= word_addr;
        wdata_q <= st_data;
        be_q    <= st_be;
        we_q    <= i_req_wr;
        f3_q    <= i_f3;
        off_q   <= i_addr[1:0];
        cnt_q   <= '0;
      end
      if (ack_hit) begin
        cnt_q   <= '0;
        err_q   <= 1'b0;
        rdata_q <= we_q ? '0 : ld_data;
      end else if (abort) begin
        cnt_q   <= '0;
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if (state == ST_BUS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (sc_fail) begin
        rdata_q <= XLEN'(1);
        err_q   <= 1'b0;
      end
      if (state == ST_DONE) err_q <= 1'b0;
    end
  end

  assign o_rdata     = rdata_q;
  assign o_err       = err_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_be    = be_q;

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bridge directly downstream of the data-memory stage of the single-cycle core.
- Consumes one load/store request per instruction: byte/half/word address, store data and funct3.
- Drives a word-wide external memory port with a req/ack handshake, byte enables and a bus timeout.
- Returns lane-aligned, sign/zero-extended load data, and holds the core stalled until the access completes.

Parameters:
- XLEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, maximum number of BUS cycles without ack before the access is aborted (minimum 1).

Ports:
- i_clk  in  1  clock. Single clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_rd  in  1  load request; held stable while o_stall=1.
- i_req_wr  in  1  store request; held stable while o_stall=1.
- i_addr  in  XLEN  byte address.
- i_wdata  in  XLEN  store data, right-aligned.
- i_f3  in  3  funct3: size and signedness.
- o_rdata  out  XLEN  extended load data; valid in DONE.
- o_stall  out  1  access in progress.
- o_err  out  1  bus timeout; pulses in DONE.
- o_mem_req  out  1  bus request.
- o_mem_we  out  1  bus write.
- o_mem_addr  out  XLEN  word address, bits[1:0]=0.
- o_mem_wdata  out  XLEN  lane-steered store data.
- o_mem_be  out  4  byte enables.
- i_mem_rdata  in  XLEN  bus read word.
- i_mem_ack  in  1  bus completion; one cycle.

Behaviour:
- Reset: state IDLE; o_rdata=0, o_err=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_mem_be=0, timeout counter=0.
- Reset mid-access: drops o_mem_req on the next cycle; a late ack is ignored in IDLE.
- FSM IDLE -> BUS -> DONE -> IDLE.
- o_stall is combinational: (IDLE & (i_req_rd | i_req_wr)) | BUS. It is 0 in DONE.
- IDLE, on request:
  - register word address, steered wdata, be, we, f3 and addr[1:0]; go to BUS.
  - If i_req_rd and i_req_wr are both set, the write wins.
- BUS:
  - o_mem_req=1 and the registered fields are driven, constant for the whole access.
  - On i_mem_ack: capture the extended read (reads only), go to DONE, clear the counter.
  - Otherwise the counter increments. At count==TIMEOUT_CYCLES-1 without ack: abort, o_rdata=0, o_err=1, go to DONE.
- DONE:
  - one cycle, o_stall=0; the core advances at this edge.
  - o_err clears on leaving DONE.
  - Then IDLE unconditionally, even if the request is still visible.
- Latency: ack in the first BUS cycle gives 3 cycles request-to-release; each extra wait cycle adds 1.
- Stores:
  - SB (000): be=1<<a[1:0], data byte replicated on all lanes.
  - SH (001): be=a[1]?1100:0011, halfword duplicated.
  - SW (010): be=1111.
- Loads:
  - LB 000 / LBU 100: select byte a[1:0], sign/zero extend.
  - LH 001 / LHU 101: select half a[1], sign/zero extend.
  - LW 010: full word.
- Misaligned halfword/word requests: the upstream stage suppresses them. If one arrives anyway, the ignored low address bits are treated as 0.
- Undefined funct3: treated as word width, no extension.

Optional Feature:
- ARVI_DMEM_RESERVATION_EN adds ports i_lr and i_sc (1 bit each, qualify i_req_rd and i_req_wr), plus a reservation valid bit and word-address register.
- LR completion sets the reservation to the LR word address.
- SC when reservation valid and word address matches: issues the write; o_rdata=0 in DONE.
- SC otherwise: no bus access, IDLE -> DONE directly (BUS skipped), o_rdata=1.
- Every SC clears the reservation. Any store to the reserved word clears it. Reset clears it.
- Without the macro: ports and reservation logic are absent; i_req_rd/i_req_wr behave as plain load/store.

Decomposition:
- Package arvi_dmem_pkg: FSM state enum, funct3 localparams (F3_B/H/W/BU/HU), be width constant.
- Natural sub-module: dmem_lane_align. It is combinational store steering/byte-enable generation plus load select/extend, and is reusable by the cache path.

Test Plan:
- LB at addr 0x103, bus word 0x80FF_0000, ack after 2 waits -> o_rdata=0xFFFF_FF80; o_stall high 4 cycles; o_mem_addr=0x100.
- SH 0xABCD at addr 0x202, immediate ack -> be=1100, o_mem_wdata=0xABCD_ABCD, we=1; stall released after 3 cycles.
- LHU at addr 0x0 from 0x1234_F00D -> o_rdata=0x0000_F00D. LW from the same word -> 0x1234_F00D.
- No ack with TIMEOUT_CYCLES=4 -> o_mem_req drops after 4 BUS cycles; DONE with o_err=1, o_rdata=0.
- i_rst asserted during BUS, then ack -> state IDLE, o_mem_req=0 the next cycle, outputs at reset values, ack ignored.
- (EN) LR 0x40, SC 0x40 -> write issued, o_rdata=0. A second SC 0x40 -> no bus req, o_rdata=1.
